// File: rtl/path_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : path_sequencer
// Brief    : Steps through a small program of {COMMAND, PATH, DISTANCE}
//            entries, handing one entry at a time to the navigation
//            controller and advancing on each NEXT_FLAG rising edge.
//            A per-step watchdog timer forces a FAULT if the controller
//            stalls; an all-zero COMMAND byte marks the end of the program.
// Revision : 1.0 - initial release
// ============================================================================
module path_sequencer #(
  parameter int STEPS   = 16,
  parameter int TIMEOUT = 50000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic        WR_EN,
  input  logic [3:0]  WR_ADDR,
  input  logic [23:0] WR_DATA,
  input  logic        NEXT_FLAG,
  output logic [7:0]  COMMAND,
  output logic [7:0]  PATH,
  output logic [7:0]  COMPARE_DISTANCE,
  output logic [1:0]  RUN_FLAG,
  output logic [3:0]  STEP,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam logic [3:0]  c_LAST_STEP    = 4'(STEPS - 1);
  localparam logic [4:0]  c_DEPTH        = 5'(STEPS);
  localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [1:0]  c_FLAG_IDLE    = 2'b00;
  localparam logic [1:0]  c_FLAG_RUN     = 2'b01;
  localparam logic [1:0]  c_FLAG_DONE    = 2'b10;
  localparam logic [1:0]  c_FLAG_FAULT   = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_mem [STEPS];
  logic [23:0] r_entry;
  logic [3:0]  r_step;
  logic [3:0]  w_step_nxt;
  logic [7:0]  r_cmd;
  logic [7:0]  w_cmd_nxt;
  logic [7:0]  r_path;
  logic [7:0]  w_path_nxt;
  logic [7:0]  r_dist;
  logic [7:0]  w_dist_nxt;
  logic [1:0]  r_flag;
  logic [1:0]  w_flag_nxt;
  logic [31:0] r_timer;
  logic [31:0] w_timer_nxt;
  logic        r_start;
  logic        r_nf;
  logic        r_nf_q;
  logic        w_rise;
  logic        w_timeout;
  logic        w_marker;
  logic        w_can_load;
  logic        w_can_start;

  // The program may only change while nothing is executing it.
  assign w_can_load  = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                       (r_state == ST_FAULT);
  // START is only meaningful where a run can begin; FAULT needs ABORT first.
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // Rise seen between the two edge-register stages, so a level held high
  // across FETCH/ISSUE never looks like a fresh completion.
  assign w_rise      = r_nf & ~r_nf_q;
  assign w_timeout   = (r_timer == c_TIMEOUT_LAST);
  assign w_marker    = (r_entry[23:16] == 8'h00);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of the step outputs, step pointer and timer.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cmd_nxt   = r_cmd;
    w_path_nxt  = r_path;
    w_dist_nxt  = r_dist;
    w_flag_nxt  = r_flag;
    w_timer_nxt = r_timer;
    if (ABORT) begin
      w_state_nxt = ST_IDLE;
      w_step_nxt  = '0;
      w_cmd_nxt   = '0;
      w_path_nxt  = '0;
      w_dist_nxt  = '0;
      w_flag_nxt  = c_FLAG_IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (r_start) begin
            w_state_nxt = ST_FETCH;
            w_step_nxt  = '0;
            w_cmd_nxt   = '0;
            w_path_nxt  = '0;
            w_dist_nxt  = '0;
            w_flag_nxt  = c_FLAG_IDLE;
          end
        end
        ST_FETCH: begin
          w_state_nxt = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (w_marker) begin
            w_state_nxt = ST_DONE;
            w_cmd_nxt   = '0;
            w_path_nxt  = '0;
            w_dist_nxt  = '0;
            w_flag_nxt  = c_FLAG_DONE;
          end else begin
            w_state_nxt = ST_RUN;
            w_cmd_nxt   = r_entry[23:16];
            w_path_nxt  = r_entry[15:8];
            w_dist_nxt  = r_entry[7:0];
            w_flag_nxt  = c_FLAG_RUN;
            w_timer_nxt = '0;
          end
        end
        ST_RUN: begin
          // A completion edge outranks a timeout landing on the same cycle.
          if (w_rise) begin
            if (r_step == c_LAST_STEP) begin
              w_state_nxt = ST_DONE;
              w_cmd_nxt   = '0;
              w_path_nxt  = '0;
              w_dist_nxt  = '0;
              w_flag_nxt  = c_FLAG_DONE;
            end else begin
              w_state_nxt = ST_FETCH;
              w_step_nxt  = r_step + 4'd1;
            end
          end else if (w_timeout) begin
            w_state_nxt = ST_FAULT;
            w_cmd_nxt   = '0;
            w_path_nxt  = '0;
            w_dist_nxt  = '0;
            w_flag_nxt  = c_FLAG_FAULT;
          end else begin
            w_timer_nxt = r_timer + 32'd1;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = '0;
          w_cmd_nxt   = '0;
          w_path_nxt  = '0;
          w_dist_nxt  = '0;
          w_flag_nxt  = c_FLAG_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // Step outputs, pointer and watchdog timer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_step  <= '0;
      r_cmd   <= '0;
      r_path  <= '0;
      r_dist  <= '0;
      r_flag  <= c_FLAG_IDLE;
      r_timer <= '0;
    end else begin
      r_step  <= w_step_nxt;
      r_cmd   <= w_cmd_nxt;
      r_path  <= w_path_nxt;
      r_dist  <= w_dist_nxt;
      r_flag  <= w_flag_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // START capture (ABORT wins) and the two-stage NEXT_FLAG edge register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_start <= 1'b0;
      r_nf    <= 1'b0;
      r_nf_q  <= 1'b0;
    end else begin
      r_start <= START & ~ABORT & w_can_start;
      r_nf    <= NEXT_FLAG;
      r_nf_q  <= r_nf;
    end
  end

  // Program memory writes; the whole array clears on reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < STEPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (WR_EN && w_can_load && ({1'b0, WR_ADDR} < c_DEPTH)) begin
      r_mem[WR_ADDR] <= WR_DATA;
    end
  end

  // Registered read of the entry at the current step during FETCH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_entry <= '0;
    end else if (r_state == ST_FETCH) begin
      r_entry <= r_mem[r_step];
    end
  end

  assign COMMAND          = r_cmd;
  assign PATH             = r_path;
  assign COMPARE_DISTANCE = r_dist;
  assign RUN_FLAG         = r_flag;
  assign STEP             = r_step;
  assign BUSY             = (r_state == ST_FETCH) || (r_state == ST_ISSUE) ||
                            (r_state == ST_RUN);

endmodule
`default_nettype wire
